// File: rtl/conv_center_scheduler_if.sv
// Bus bundle for conv_center_scheduler: layer control, Allocator fan-out/fan-in
// and the raster-ordered result stream. master = scheduler side, slave = environment.
interface conv_center_scheduler_if #(
  parameter int unsigned NUM_ALLOC = 4,
  parameter int unsigned COORD_W   = 8,
  parameter int unsigned DATA_W    = 18
);
  logic                        start;
  logic [COORD_W-1:0]          img_width;
  logic [COORD_W-1:0]          img_height;
  logic [2:0]                  filter_dim;
  logic                        busy;
  logic                        done;
  logic [COORD_W-1:0]          center_x;
  logic [COORD_W-1:0]          center_y;
  logic [NUM_ALLOC-1:0]        center_write_enable;
  logic [NUM_ALLOC-1:0]        alloc_result_ready;
  logic [NUM_ALLOC*DATA_W-1:0] alloc_result_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [COORD_W-1:0]          out_x;
  logic [COORD_W-1:0]          out_y;

  modport master (
    input  start, img_width, img_height, filter_dim,
    input  alloc_result_ready, alloc_result_data, out_ready,
    output busy, done, center_x, center_y, center_write_enable,
    output out_valid, out_data, out_x, out_y
  );

  modport slave (
    output start, img_width, img_height, filter_dim,
    output alloc_result_ready, alloc_result_data, out_ready,
    input  busy, done, center_x, center_y, center_write_enable,
    input  out_valid, out_data, out_x, out_y
  );
endinterface

// File: rtl/conv_center_scheduler.sv
// conv_center_scheduler: walks output centers of one convolution layer in raster
// order, deals them round-robin to NUM_ALLOC Allocators and re-emits the results in
// raster order on a ready/valid stream.
// Optional feature macro: SCHED_STATS_EN adds the stall_cycles counter output.
module conv_center_scheduler #(
  parameter int unsigned NUM_ALLOC = 4,
  parameter int unsigned COORD_W   = 8,
  parameter int unsigned DATA_W    = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  conv_center_scheduler_if.master  bus
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned PTR_W = (NUM_ALLOC > 1) ? $clog2(NUM_ALLOC) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ALLOC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [1:0] SL_FREE = 2'd0;
  localparam logic [1:0] SL_PEND = 2'd1;
  localparam logic [1:0] SL_FULL = 2'd2;

  logic [1:0]           r_state;
  logic                 r_busy;
  logic                 r_done;
  logic [COORD_W-1:0]   r_half;
  logic [COORD_W:0]     r_x_last;
  logic [COORD_W:0]     r_y_last;
  logic [COORD_W-1:0]   r_cx;
  logic [COORD_W-1:0]   r_cy;

  logic [COORD_W-1:0]   r_center_x;
  logic [COORD_W-1:0]   r_center_y;
  logic [NUM_ALLOC-1:0] r_cwe;
  logic [PTR_W-1:0]     r_issue_ptr;
  logic [PTR_W-1:0]     r_retire_ptr;

  logic [1:0]           r_slot_st   [NUM_ALLOC];
  logic [DATA_W-1:0]    r_slot_data [NUM_ALLOC];
  logic [COORD_W-1:0]   r_slot_x    [NUM_ALLOC];
  logic [COORD_W-1:0]   r_slot_y    [NUM_ALLOC];

  logic                 r_out_valid;
  logic [DATA_W-1:0]    r_out_data;
  logic [COORD_W-1:0]   r_out_x;
  logic [COORD_W-1:0]   r_out_y;

  logic [2:0]           w_half_in;
  logic [COORD_W:0]     w_half_ext;
  logic [COORD_W:0]     w_x_last;
  logic [COORD_W:0]     w_y_last;
  logic                 w_empty;
  logic                 w_start_ok;
  logic                 w_issue_free;
  logic                 w_do_issue;
  logic                 w_x_end;
  logic                 w_y_end;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_all_free;

  // Config decode; all bound arithmetic in COORD_W+1 bits so 255-wide images don't wrap.
  assign w_half_in  = bus.filter_dim >> 1;
  assign w_half_ext = {{(COORD_W-2){1'b0}}, w_half_in};
  assign w_x_last   = {1'b0, bus.img_width} - (COORD_W+1)'(1) - w_half_ext;
  assign w_y_last   = {1'b0, bus.img_height} - (COORD_W+1)'(1) - w_half_ext;
  assign w_empty    = ({1'b0, bus.img_width} <= (w_half_ext << 1)) ||
                      ({1'b0, bus.img_height} <= (w_half_ext << 1));
  assign w_start_ok = (r_state == ST_IDLE) && bus.start;

  assign w_issue_free = (r_slot_st[r_issue_ptr] == SL_FREE);
  assign w_do_issue   = (r_state == ST_ISSUE) && w_issue_free;
  assign w_x_end      = ({1'b0, r_cx} == r_x_last);
  assign w_y_end      = ({1'b0, r_cy} == r_y_last);
  assign w_accept     = r_out_valid && bus.out_ready;
  assign w_load       = !r_out_valid && (r_slot_st[r_retire_ptr] == SL_FULL);

  // Drain completes only once every slot has handed its result downstream.
  always_comb begin
    w_all_free = 1'b1;
    for (int i = 0; i < NUM_ALLOC; i++) begin
      if (r_slot_st[i] != SL_FREE) w_all_free = 1'b0;
    end
  end

  // Layer FSM, config latch and raster walk of the next center to issue.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_half   <= '0;
      r_x_last <= '0;
      r_y_last <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_busy   <= 1'b1;
            r_half   <= w_half_ext[COORD_W-1:0];
            r_x_last <= w_x_last;
            r_y_last <= w_y_last;
            r_cx     <= w_half_ext[COORD_W-1:0];
            r_cy     <= w_half_ext[COORD_W-1:0];
            r_state  <= w_empty ? ST_FINISH : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_do_issue) begin
            if (w_x_end) begin
              r_cx <= r_half;
              if (w_y_end) r_state <= ST_DRAIN;
              else         r_cy <= r_cy + COORD_W'(1);
            end else begin
              r_cx <= r_cx + COORD_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_all_free && !r_out_valid) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Issue port: one-cycle one-hot strobe plus shared coordinates; round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cwe       <= '0;
      r_center_x  <= '0;
      r_center_y  <= '0;
      r_issue_ptr <= '0;
    end else begin
      r_cwe <= '0;
      if (w_start_ok) begin
        r_issue_ptr <= '0;
      end else if (w_do_issue) begin
        r_cwe       <= NUM_ALLOC'(1) << r_issue_ptr;
        r_center_x  <= r_cx;
        r_center_y  <= r_cy;
        r_issue_ptr <= (r_issue_ptr == PTR_LAST) ? '0 : r_issue_ptr + PTR_W'(1);
      end
    end
  end

  // Per-slot FREE -> PENDING -> FULL -> FREE; each transition needs a distinct
  // source state, so issue, capture and retire never collide on one slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ALLOC; i++) begin
        r_slot_st[i]   <= SL_FREE;
        r_slot_data[i] <= '0;
        r_slot_x[i]    <= '0;
        r_slot_y[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALLOC; i++) begin
        if (w_do_issue && (r_issue_ptr == PTR_W'(i))) begin
          r_slot_st[i] <= SL_PEND;
          r_slot_x[i]  <= r_cx;
          r_slot_y[i]  <= r_cy;
        end else if ((r_slot_st[i] == SL_PEND) && bus.alloc_result_ready[i]) begin
          r_slot_st[i]   <= SL_FULL;
          r_slot_data[i] <= bus.alloc_result_data[i*DATA_W +: DATA_W];
        end else if (w_accept && (r_retire_ptr == PTR_W'(i))) begin
          r_slot_st[i] <= SL_FREE;
        end
      end
    end
  end

  // Retire stage: registered output of the slot at retire_ptr, held until accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_retire_ptr <= '0;
    end else if (w_start_ok) begin
      r_retire_ptr <= '0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b0;
      r_retire_ptr <= (r_retire_ptr == PTR_LAST) ? '0 : r_retire_ptr + PTR_W'(1);
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_slot_data[r_retire_ptr];
      r_out_x     <= r_slot_x[r_retire_ptr];
      r_out_y     <= r_slot_y[r_retire_ptr];
    end
  end

`ifdef SCHED_STATS_EN
  logic [31:0] r_stall;

  // Counts ISSUE cycles blocked by a busy slot; saturating, cleared on each new layer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (w_start_ok) begin
      r_stall <= '0;
    end else if ((r_state == ST_ISSUE) && !w_issue_free && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end

  assign stall_cycles = r_stall;
`endif

  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.center_x            = r_center_x;
  assign bus.center_y            = r_center_y;
  assign bus.center_write_enable = r_cwe;
  assign bus.out_valid           = r_out_valid;
  assign bus.out_data            = r_out_data;
  assign bus.out_x               = r_out_x;
  assign bus.out_y               = r_out_y;

endmodule

// File: tb/tb_conv_center_scheduler.sv
// Testbench for conv_center_scheduler: table of layer configs run against an
// Allocator model with a raster-order scoreboard, plus reset/stall sequences.
module tb_conv_center_scheduler;

  localparam int unsigned NA = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned DW = 18;
  localparam int BUDGET = 4000;

  typedef struct {
    int w;
    int h;
    int dim;
    int lat0;
    int lato;
    int hold;
    int exp_done_c;
  } vec_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [DW-1:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
`ifdef SCHED_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];

  conv_center_scheduler_if #(.NUM_ALLOC(NA), .COORD_W(CW), .DATA_W(DW)) bus ();

  conv_center_scheduler #(
    .NUM_ALLOC(NA),
    .COORD_W  (CW),
    .DATA_W   (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef SCHED_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkdata(input int x, input int y, input int s, input int salt);
    return DW'((x * 131 + y * 17 + s * 4099 + salt * 7) & 32'h3FFFF);
  endfunction

  task automatic run_layer(input vec_t v, input int salt);
    int half, issued, accepted, done_cnt, end_c, slot, c;
    int exp_cx[$];
    int exp_cy[$];
    int tmr[NA];
    bit act[NA];
    logic [DW-1:0] adat[NA];
    logic [DW-1:0] d;
    bit held_v;
    logic [DW-1:0] h_d;
    logic [CW-1:0] h_x, h_y;
    exp_t e;

    half = v.dim / 2;
    for (int y = half; y <= v.h - 1 - half; y++)
      for (int x = half; x <= v.w - 1 - half; x++) begin
        exp_cx.push_back(x);
        exp_cy.push_back(y);
      end
    for (int i = 0; i < NA; i++) begin
      act[i] = 1'b0;
      tmr[i] = 0;
      adat[i] = '0;
    end
    issued = 0; accepted = 0; done_cnt = 0; end_c = -1; held_v = 1'b0;
    sb_q.delete();

    bus.img_width  = CW'(v.w);
    bus.img_height = CW'(v.h);
    bus.filter_dim = 3'(v.dim);
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;

    c = 0;
    while (c < BUDGET && c != end_c) begin
      bus.alloc_result_ready = '0;
      bus.out_ready = (c >= v.hold);
      if (c == 0) begin
        chk("busy_after_start", bus.busy, 1);
`ifdef SCHED_STATS_EN
        chk("stall_cleared", stall_cycles, 0);
`endif
      end
      if (bus.center_write_enable != '0) begin
        slot = issued % NA;
        chk("strobe_onehot", bus.center_write_enable, NA'(1) << slot);
        chk("outstanding_le_na", (issued - accepted) <= NA, 1);
        if (issued < exp_cx.size()) begin
          chk("center_x", bus.center_x, exp_cx[issued]);
          chk("center_y", bus.center_y, exp_cy[issued]);
        end
        d = mkdata(bus.center_x, bus.center_y, slot, salt);
        act[slot]  = 1'b1;
        tmr[slot]  = ((slot == 0) ? v.lat0 : v.lato) - 1;
        adat[slot] = d;
        e.x = bus.center_x; e.y = bus.center_y; e.d = d;
        sb_q.push_back(e);
        issued++;
      end
      for (int i = 0; i < NA; i++) begin
        if (act[i]) begin
          if (tmr[i] == 0) begin
            bus.alloc_result_ready[i] = 1'b1;
            bus.alloc_result_data[i*DW +: DW] = adat[i];
            act[i] = 1'b0;
          end else begin
            tmr[i]--;
          end
        end
      end
      if (bus.out_valid) begin
        if (held_v) begin
          chk("hold_data", bus.out_data, h_d);
          chk("hold_x", bus.out_x, h_x);
          chk("hold_y", bus.out_y, h_y);
        end
        if (bus.out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("out_x", bus.out_x, e.x);
            chk("out_y", bus.out_y, e.y);
            chk("out_data", bus.out_data, e.d);
          end
          accepted++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          h_d = bus.out_data; h_x = bus.out_x; h_y = bus.out_y;
        end
      end else begin
        if (held_v) chk("valid_dropped", 0, 1);
        held_v = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        chk("busy_low_at_done", bus.busy, 0);
        if (v.exp_done_c >= 0) chk("done_cycle", c, v.exp_done_c);
        if (end_c < 0) end_c = c + 3;
      end else if (done_cnt == 0 && c > 0) begin
        if (bus.busy !== 1'b1) chk("busy_during_layer", bus.busy, 1);
      end
      step();
      c++;
    end
    bus.alloc_result_ready = '0;
    chk("done_once", done_cnt, 1);
    chk("issued_count", issued, exp_cx.size());
    chk("accepted_count", accepted, exp_cx.size());
    chk("scoreboard_empty", sb_q.size(), 0);
`ifdef SCHED_STATS_EN
    if (v.hold > 0) chk("stall_counted", stall_cycles != 0, 1);
`endif
  endtask

  vec_t vecs[7];
  int strobes;

  initial begin
    vecs[0] = '{w: 4,   h: 4, dim: 3, lat0: 1,  lato: 1, hold: 0,  exp_done_c: -1};
    vecs[1] = '{w: 4,   h: 4, dim: 3, lat0: 20, lato: 2, hold: 0,  exp_done_c: -1};
    vecs[2] = '{w: 5,   h: 3, dim: 3, lat0: 1,  lato: 1, hold: 50, exp_done_c: -1};
    vecs[3] = '{w: 2,   h: 9, dim: 3, lat0: 1,  lato: 1, hold: 0,  exp_done_c: 1};
    vecs[4] = '{w: 9,   h: 7, dim: 3, lat0: 3,  lato: 1, hold: 40, exp_done_c: -1};
    vecs[5] = '{w: 7,   h: 7, dim: 7, lat0: 2,  lato: 2, hold: 0,  exp_done_c: -1};
    vecs[6] = '{w: 255, h: 3, dim: 1, lat0: 1,  lato: 3, hold: 0,  exp_done_c: -1};

    bus.start = 1'b1;
    bus.img_width = 8'd4;
    bus.img_height = 8'd4;
    bus.filter_dim = 3'd3;
    bus.alloc_result_ready = '0;
    bus.alloc_result_data = '0;
    bus.out_ready = 1'b1;

    // Reset held with start asserted: nothing may begin.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_busy", bus.busy, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_cwe", bus.center_write_enable, 0);
      chk("rst_done", bus.done, 0);
    end
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_center_x", bus.center_x, 0);
    bus.start = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_busy", bus.busy, 0);
      chk("idle_cwe", bus.center_write_enable, 0);
    end

    for (int k = 0; k < 7; k++) run_layer(vecs[k], k + 1);

    // Allocators never answer: exactly NA issues then stall; then reset mid-layer.
    bus.img_width = 8'd8;
    bus.img_height = 8'd8;
    bus.filter_dim = 3'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.center_write_enable != '0) strobes++;
      step();
    end
    chk("stall_issue_count", strobes, NA);
    chk("stall_busy", bus.busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_cwe", bus.center_write_enable, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_center_y", bus.center_y, 0);
    bus.alloc_result_ready = '1;
    bus.alloc_result_data = '1;
    step();
    step();
    bus.alloc_result_ready = '0;
    for (int i = 0; i < 4; i++) begin
      chk("stale_ignored_valid", bus.out_valid, 0);
      chk("stale_ignored_busy", bus.busy, 0);
      step();
    end
    run_layer('{w: 8, h: 8, dim: 3, lat0: 2, lato: 2, hold: 0, exp_done_c: -1}, 99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
